// File: rtl/access_session_manager.sv
// -----------------------------------------------------------------------------
// access_session_manager
//
// Purpose:
//   Runs the login session that follows the user-ID / password access-control
//   stage. It watches the verdict lamps coming from that stage and:
//     - counts failed attempts and enforces a timed lockout;
//     - expires sessions after a fixed number of clocks;
//     - emits a one-cycle logout pulse that is fed back to both upstream
//       controllers so they return to their start state.
//
// Configuration macro:
//   SESSION_EXTEND_EN - when defined, a fresh rising edge on user_ok or pwd_ok
//                       during SESSION reloads the session timer. This keeps an
//                       active session alive. When undefined, those edges are
//                       ignored in SESSION and every session has a fixed length.
//
// Parameters:
//   MAX_ATTEMPTS   failures (user-ID or password) that trigger lockout (1..15)
//   LOCKOUT_CYCLES clocks spent in LOCKED (>=1)
//   SESSION_CYCLES clocks a session lasts before a forced logout (>=1)
//   CNT_W          timer width; must hold max(LOCKOUT_CYCLES, SESSION_CYCLES)
//
// Ports:
//   clk            in   1  system clock, rising edge
//   reset          in   1  asynchronous, active-high; clears all state
//   user_ok        in   1  user-ID accepted (level)
//   user_fail      in   1  user-ID rejected (level)
//   pwd_ok         in   1  password accepted (level)
//   pwd_fail       in   1  password rejected (level)
//   logout_req     in   1  user logout button (level, already synchronised)
//   session_active out  1  high while in SESSION
//   lockout        out  1  high while in LOCKED
//   fail_count     out  4  failures since last success/lockout, saturates
//   logout_out     out  1  one-cycle logout pulse to the upstream stages
//   state_out      out  2  IDLE=0, WAIT_PWD=1, SESSION=2, LOCKED=3
// -----------------------------------------------------------------------------
module access_session_manager #(
  parameter int MAX_ATTEMPTS   = 3,
  parameter int LOCKOUT_CYCLES = 1000,
  parameter int SESSION_CYCLES = 5000,
  parameter int CNT_W          = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       user_ok,
  input  logic       user_fail,
  input  logic       pwd_ok,
  input  logic       pwd_fail,
  input  logic       logout_req,
  output logic       session_active,
  output logic       lockout,
  output logic [3:0] fail_count,
  output logic       logout_out,
  output logic [1:0] state_out
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_PWD = 2'd1,
    ST_SESSION  = 2'd2,
    ST_LOCKED   = 2'd3
  } state_t;

  localparam logic [3:0]       MAX_L     = 4'(MAX_ATTEMPTS);
  localparam logic [CNT_W-1:0] LOCK_LOAD = CNT_W'(LOCKOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] SESS_LOAD = CNT_W'(SESSION_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMER_ONE = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [3:0]       r_fail_count;
  logic             r_logout;

  // Delayed copies of the level inputs, used for rising-edge detection.
  logic r_user_ok_q;
  logic r_user_fail_q;
  logic r_pwd_ok_q;
  logic r_pwd_fail_q;
  logic r_logout_req_q;

  // ---------------------------------------------------------------------------
  // Next-state signals
  // ---------------------------------------------------------------------------
  state_t           w_state_next;
  logic [CNT_W-1:0] w_timer_next;
  logic [3:0]       w_fail_next;
  logic             w_logout_next;

  logic w_rise_user_ok;
  logic w_rise_user_fail;
  logic w_rise_pwd_ok;
  logic w_rise_pwd_fail;
  logic w_rise_logout;

  logic [3:0] w_fail_inc;
  logic       w_fail_limit;
  logic       w_timer_zero;
  logic [CNT_W-1:0] w_timer_dec;

  assign w_rise_user_ok   = user_ok    & ~r_user_ok_q;
  assign w_rise_user_fail = user_fail  & ~r_user_fail_q;
  assign w_rise_pwd_ok    = pwd_ok     & ~r_pwd_ok_q;
  assign w_rise_pwd_fail  = pwd_fail   & ~r_pwd_fail_q;
  assign w_rise_logout    = logout_req & ~r_logout_req_q;

  // The counter only increments while below the limit, so the +1 never wraps.
  assign w_fail_inc   = r_fail_count + 4'd1;
  assign w_fail_limit = (w_fail_inc >= MAX_L);
  assign w_timer_zero = (r_timer == '0);
  assign w_timer_dec  = w_timer_zero ? r_timer : (r_timer - TIMER_ONE);

  // ---------------------------------------------------------------------------
  // Edge-detect registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_user_ok_q    <= 1'b0;
      r_user_fail_q  <= 1'b0;
      r_pwd_ok_q     <= 1'b0;
      r_pwd_fail_q   <= 1'b0;
      r_logout_req_q <= 1'b0;
    end else begin
      r_user_ok_q    <= user_ok;
      r_user_fail_q  <= user_fail;
      r_pwd_ok_q     <= pwd_ok;
      r_pwd_fail_q   <= pwd_fail;
      r_logout_req_q <= logout_req;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_timer      <= '0;
      r_fail_count <= 4'd0;
      r_logout     <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_timer      <= w_timer_next;
      r_fail_count <= w_fail_next;
      r_logout     <= w_logout_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next  = r_state;
    w_timer_next  = '0;           // timer rests at 0 outside SESSION/LOCKED
    w_fail_next   = r_fail_count;
    w_logout_next = 1'b0;

    case (r_state)
      ST_IDLE: begin
        // A failure edge takes priority over a simultaneous success edge.
        if (w_rise_user_fail) begin
          if (w_fail_limit) begin
            w_state_next  = ST_LOCKED;
            w_timer_next  = LOCK_LOAD;
            w_fail_next   = MAX_L;
            w_logout_next = 1'b1;   // clear the upstream stages on lockout
          end else begin
            w_fail_next = w_fail_inc;
          end
        end else if (w_rise_user_ok) begin
          w_state_next = ST_WAIT_PWD;
        end
      end

      ST_WAIT_PWD: begin
        // Logout beats any password verdict; failure beats success.
        if (w_rise_logout) begin
          w_state_next  = ST_IDLE;
          w_logout_next = 1'b1;
        end else if (w_rise_pwd_fail) begin
          if (w_fail_limit) begin
            w_state_next  = ST_LOCKED;
            w_timer_next  = LOCK_LOAD;
            w_fail_next   = MAX_L;
            w_logout_next = 1'b1;
          end else begin
            w_fail_next = w_fail_inc;
          end
        end else if (w_rise_pwd_ok) begin
          w_state_next = ST_SESSION;
          w_timer_next = SESS_LOAD;
          w_fail_next  = 4'd0;
        end
      end

      ST_SESSION: begin
`ifdef SESSION_EXTEND_EN
        // An explicit logout still ends the session even alongside activity;
        // activity alone outranks the expiry of the timer.
        if (w_rise_logout) begin
          w_state_next  = ST_IDLE;
          w_logout_next = 1'b1;
        end else if (w_rise_user_ok || w_rise_pwd_ok) begin
          w_timer_next = SESS_LOAD;
        end else if (w_timer_zero) begin
          w_state_next  = ST_IDLE;
          w_logout_next = 1'b1;
        end else begin
          w_timer_next = w_timer_dec;
        end
`else
        // Expiry and logout in the same cycle collapse into one pulse.
        if (w_rise_logout || w_timer_zero) begin
          w_state_next  = ST_IDLE;
          w_logout_next = 1'b1;
        end else begin
          w_timer_next = w_timer_dec;
        end
`endif
      end

      ST_LOCKED: begin
        // All inputs are ignored here. With a one-cycle lockout the exit would
        // follow the entry pulse immediately; waiting while r_logout is still
        // high keeps the two logout pulses from merging into one long pulse.
        if (w_timer_zero && !r_logout) begin
          w_state_next  = ST_IDLE;
          w_fail_next   = 4'd0;
          w_logout_next = 1'b1;
        end else begin
          w_timer_next = w_timer_dec;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Outputs (all decoded from registered state)
  // ---------------------------------------------------------------------------
  assign session_active = (r_state == ST_SESSION);
  assign lockout        = (r_state == ST_LOCKED);
  assign fail_count     = r_fail_count;
  assign logout_out     = r_logout;
  assign state_out      = r_state;

endmodule

// File: tb/tb_access_session_manager.sv
// -----------------------------------------------------------------------------
// tb_access_session_manager
//
// Directed testbench for access_session_manager with MAX_ATTEMPTS=3,
// LOCKOUT_CYCLES=8, SESSION_CYCLES=10. Inputs change 1 ns after a rising edge
// and outputs are sampled 1 ns after the following rising edge.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_access_session_manager;

  logic       clk;
  logic       reset;
  logic       user_ok;
  logic       user_fail;
  logic       pwd_ok;
  logic       pwd_fail;
  logic       logout_req;
  logic       session_active;
  logic       lockout;
  logic [3:0] fail_count;
  logic       logout_out;
  logic [1:0] state_out;

  int n_tests = 0;
  int n_fail  = 0;
  int pulse_cnt = 0;
  int double_pulse = 0;
  int p_base;
  logic prev_logout = 1'b0;

  access_session_manager #(
    .MAX_ATTEMPTS  (3),
    .LOCKOUT_CYCLES(8),
    .SESSION_CYCLES(10),
    .CNT_W         (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .user_ok       (user_ok),
    .user_fail     (user_fail),
    .pwd_ok        (pwd_ok),
    .pwd_fail      (pwd_fail),
    .logout_req    (logout_req),
    .session_active(session_active),
    .lockout       (lockout),
    .fail_count    (fail_count),
    .logout_out    (logout_out),
    .state_out     (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Logout pulse monitor: counts high cycles and flags back-to-back pulses.
  always @(negedge clk) begin
    if (logout_out) pulse_cnt++;
    if (logout_out && prev_logout) double_pulse++;
    prev_logout = logout_out;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    $display("[TB] %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; user_ok = 0; user_fail = 0; pwd_ok = 0; pwd_fail = 0; logout_req = 0;
    ticks(2);
    chk("rst_state", 32'(state_out), 32'd0);
    chk("rst_fail", 32'(fail_count), 32'd0);
    chk("rst_logout", 32'(logout_out), 32'd0);
    chk("rst_session", 32'(session_active), 32'd0);
    chk("rst_lockout", 32'(lockout), 32'd0);
    reset = 1'b0;
    tick();

    // ---- Session start and timed expiry --------------------------------
    user_ok = 1; tick();
    chk("t2_wait_pwd", 32'(state_out), 32'd1);
    pwd_ok = 1; tick();                  // session clk 0
    chk("t2_session", 32'(state_out), 32'd2);
    chk("t2_active", 32'(session_active), 32'd1);
    p_base = pulse_cnt;
    user_ok = 0; pwd_ok = 0;
    ticks(9);
    chk("t2_still_session", 32'(state_out), 32'd2);
    chk("t2_no_pulse_yet", 32'(logout_out), 32'd0);
    tick();                              // clk 10
    chk("t2_expired_state", 32'(state_out), 32'd0);
    chk("t2_expired_pulse", 32'(logout_out), 32'd1);
    tick();
    chk("t2_pulse_one_cycle", 32'(logout_out), 32'd0);
    chk("t2_pulse_count", 32'(pulse_cnt - p_base), 32'd1);

    // ---- Reset mid-session: immediate IDLE, no pulse --------------------
    user_ok = 1; tick();
    pwd_ok = 1; tick();
    chk("t1_in_session", 32'(state_out), 32'd2);
    ticks(3);
    p_base = pulse_cnt;
    user_ok = 0; pwd_ok = 0; reset = 1;
    #2;
    chk("t1_async_state", 32'(state_out), 32'd0);
    chk("t1_async_active", 32'(session_active), 32'd0);
    tick();
    reset = 0;
    tick(); tick();
    chk("t1_state", 32'(state_out), 32'd0);
    chk("t1_fail", 32'(fail_count), 32'd0);
    chk("t1_no_pulse", 32'(pulse_cnt - p_base), 32'd0);

    // ---- Three user-ID failures -> lockout; inputs ignored while locked ---
    p_base = pulse_cnt;
    user_fail = 1; tick();
    chk("t3_fail1", 32'(fail_count), 32'd1);
    chk("t3_idle1", 32'(state_out), 32'd0);
    user_fail = 0; tick();
    user_fail = 1; tick();
    chk("t3_fail2", 32'(fail_count), 32'd2);
    user_fail = 0; tick();
    user_fail = 1; tick();               // lock clk 0
    chk("t3_fail3", 32'(fail_count), 32'd3);
    chk("t3_locked_state", 32'(state_out), 32'd3);
    chk("t3_lockout", 32'(lockout), 32'd1);
    chk("t3_entry_pulse", 32'(logout_out), 32'd1);
    user_fail = 0;
    logout_req = 1; pwd_ok = 1;          // must have no effect while locked
    tick();                              // lock clk 1
    chk("t3_entry_pulse_end", 32'(logout_out), 32'd0);
    ticks(6);                            // lock clk 7
    chk("t5_locked_ignores", 32'(state_out), 32'd3);
    chk("t3_fail_held", 32'(fail_count), 32'd3);
    tick();                              // lock clk 8
    chk("t3_exit_state", 32'(state_out), 32'd0);
    chk("t3_exit_fail", 32'(fail_count), 32'd0);
    chk("t3_exit_pulse", 32'(logout_out), 32'd1);
    logout_req = 0; pwd_ok = 0;
    tick();
    chk("t3_pulse_count", 32'(pulse_cnt - p_base), 32'd2);

    // ---- Password failures then success --------------------------------
    user_ok = 1; tick();
    chk("t4_wait_pwd", 32'(state_out), 32'd1);
    user_ok = 0;
    pwd_fail = 1; tick();
    chk("t4_pfail1", 32'(fail_count), 32'd1);
    chk("t4_stay_wait", 32'(state_out), 32'd1);
    pwd_fail = 0; tick();
    pwd_fail = 1; tick();
    chk("t4_pfail2", 32'(fail_count), 32'd2);
    pwd_fail = 0; pwd_ok = 1; tick();
    chk("t4_session", 32'(state_out), 32'd2);
    chk("t4_fail_cleared", 32'(fail_count), 32'd0);
    pwd_ok = 0; logout_req = 1; tick();
    chk("t4_logout_state", 32'(state_out), 32'd0);
    chk("t4_logout_pulse", 32'(logout_out), 32'd1);
    logout_req = 0; tick();

    // ---- Simultaneous user_fail + user_ok: failure wins -----------------
    user_fail = 1; user_ok = 1; tick();
    chk("t4_sim_fail", 32'(fail_count), 32'd1);
    chk("t4_sim_state", 32'(state_out), 32'd0);
    user_fail = 0; user_ok = 0; tick();

    // ---- WAIT_PWD: logout_req beats pwd_ok ------------------------------
    user_ok = 1; tick();
    chk("t5_wait_pwd", 32'(state_out), 32'd1);
    user_ok = 0;
    p_base = pulse_cnt;
    logout_req = 1; pwd_ok = 1; tick();
    chk("t5_logout_wins", 32'(state_out), 32'd0);
    chk("t5_pulse", 32'(logout_out), 32'd1);
    chk("t5_fail_kept", 32'(fail_count), 32'd1);
    logout_req = 0; pwd_ok = 0; tick();
    chk("t5_pulse_count", 32'(pulse_cnt - p_base), 32'd1);

    // ---- Keep-alive: pwd_ok re-rise at session clk 7 --------------------
    user_ok = 1; tick();
    user_ok = 0;
    pwd_ok = 1; tick();                  // session clk 0
    chk("t6_session", 32'(state_out), 32'd2);
    chk("t6_fail_cleared", 32'(fail_count), 32'd0);
    pwd_ok = 0;
    ticks(6);                            // clk 6
    pwd_ok = 1; tick();                  // clk 7: re-rise
    pwd_ok = 0;
    ticks(2);                            // clk 9
    chk("t6_clk9", 32'(state_out), 32'd2);
    tick();                              // clk 10
`ifdef SESSION_EXTEND_EN
    chk("t6_clk10_extended", 32'(state_out), 32'd2);
    chk("t6_clk10_no_pulse", 32'(logout_out), 32'd0);
    ticks(6);                            // clk 16
    chk("t6_clk16", 32'(state_out), 32'd2);
    tick();                              // clk 17
    chk("t6_clk17_expired", 32'(state_out), 32'd0);
    chk("t6_clk17_pulse", 32'(logout_out), 32'd1);
`else
    chk("t6_clk10_expired", 32'(state_out), 32'd0);
    chk("t6_clk10_pulse", 32'(logout_out), 32'd1);
`endif
    ticks(2);

    chk("no_double_pulse", 32'(double_pulse), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
